// File: rtl/arb_rr_8.sv
// arb_rr_8: 8-way round-robin arbiter with bounded grant locking.
// A holder keeps the grant while its request stays high, but gives it up after
// MAX_HOLD consecutive cycles when some other requester is waiting.
module arb_rr_8 #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             vld_q, vld_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       cand;
    logic [2:0]       start;
    logic [2:0]       pos;
    logic             win_found;
    logic [2:0]       win_idx;
    logic             hold_expired;

    // Candidate set and search start: all requests from ptr when idle, everyone
    // but the holder from holder+1 when granted; then the first set bit in rotation.
    always_comb begin
        cand      = req;
        start     = ptr_q;
        pos       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        if (state_q == GRANT) begin
            cand  = req & ~(8'b1 << idx_q);
            start = idx_q + 3'd1;
        end
        for (int unsigned i = 0; i < 8; i++) begin
            pos = start + 3'(i);
            if (!win_found && cand[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
    end

    assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD)) && (cand != 8'h00);

    // Next-state logic: grant, release/expiry handover, en-drop, hold counting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (en && win_found) begin
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!en) begin
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                    state_d = IDLE;
                end else if (!req[idx_q] || hold_expired) begin
                    // Handover happens on the same edge, so there is no idle bubble.
                    ptr_d = idx_q + 3'd1;
                    if (win_found) begin
                        idx_d = win_idx;
                        vld_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
        gnt_d = vld_d ? (8'b1 << idx_d) : 8'h00;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;

endmodule
